// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned MODE_MOORE = 0;
  localparam int unsigned MODE_MEALY = 1;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector: loadable pattern, valid-qualified stream,
// overlap/non-overlap matching, Moore or Mealy output, saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned MEALY = MODE_MOORE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W out of legal range");
  end
  if ((MEALY != MODE_MOORE) && (MEALY != MODE_MEALY)) begin : g_bad_mode
    $error("seq_detector_param: MEALY must be 0 or 1");
  end

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  win;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic              match_q;
  logic              accept;
  logic              ready;
  logic              hit;

  // The oldest history bit falls off the top when the new bit is appended.
  always_comb begin
    win      = PAT_W'({hist, in});
    accept   = in_valid & ~pat_load;
    ready    = (fill >= FILL_W'(PAT_W - 1));
    hit      = accept & ready & (win == pat_q);
    fill_nxt = fill;
    if (hit && !overlap) begin
      fill_nxt = '0;
    end else if (fill != FILL_W'(PAT_W)) begin
      fill_nxt = fill + FILL_W'(1);
    end
  end

  // pat_load wins over a same-cycle beat; that beat is dropped entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist    <= '0;
      fill    <= '0;
      pat_q   <= '0;
      match_q <= 1'b0;
    end else if (pat_load) begin
      pat_q   <= pattern;
      fill    <= '0;
      match_q <= 1'b0;
    end else if (in_valid) begin
      hist    <= win;
      fill    <= fill_nxt;
      match_q <= hit;
    end
  end

  assign out = (MEALY == MODE_MEALY) ? (hit & ~reset) : match_q;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: Moore, Mealy and 2-bit-counter detectors share one stimulus stream.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic       in_valid;
  logic [3:0] pattern;
  logic       pat_load;
  logic       overlap;

  logic       mo_out, me_out, sa_out;
  logic [7:0] mo_cnt, me_cnt;
  logic [1:0] sa_cnt;

  logic [3:0] cur_pat;
  logic       cur_ov;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .CNT_W(8), .MEALY(0)) u_moore (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .pattern(pattern),
    .pat_load(pat_load), .overlap(overlap), .out(mo_out), .match_count(mo_cnt)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(8), .MEALY(1)) u_mealy (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .pattern(pattern),
    .pat_load(pat_load), .overlap(overlap), .out(me_out), .match_count(me_cnt)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2), .MEALY(0)) u_sat (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .pattern(pattern),
    .pat_load(pat_load), .overlap(overlap), .out(sa_out), .match_count(sa_cnt)
  );

  // Apply one cycle of inputs at the falling edge; return mid low-phase.
  task automatic tick(input logic r, input logic pl, input logic v, input logic b);
    @(negedge clk);
    reset    = r;
    pat_load = pl;
    in_valid = v;
    in       = b;
    pattern  = cur_pat;
    overlap  = cur_ov;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
    overlap = 1'b0; pattern = 4'b0000; cur_pat = 4'b0000; cur_ov = 1'b0;

    // Reset state
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("rst_mo_out", 32'(mo_out), 32'd0);
    chk("rst_me_out", 32'(me_out), 32'd0);
    chk("rst_mo_cnt", 32'(mo_cnt), 32'd0);
    chk("rst_sa_cnt", 32'(sa_cnt), 32'd0);

    // Scenario 1: 1011, overlap
    cur_pat = 4'b1011; cur_ov = 1'b1;
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("s1_mo_out_b4", 32'(mo_out), 32'd0);
    chk("s1_me_out_b4", 32'(me_out), 32'd1);
    chk("s1_me_cnt_b4", 32'(me_cnt), 32'd0);
    tick(0, 0, 0, 0);
    chk("s1_mo_out_after", 32'(mo_out), 32'd1);
    chk("s1_mo_cnt", 32'(mo_cnt), 32'd1);
    chk("s1_me_out_idle", 32'(me_out), 32'd0);
    chk("s1_me_cnt", 32'(me_cnt), 32'd1);

    // Scenario 2a: 1,0,1,1,0,1,1 with overlap -> two hits
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 1);
    chk("s2a_load_clears_q", 32'(mo_out), 32'd0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("s2a_me_out_b4", 32'(me_out), 32'd1);
    tick(0, 0, 1, 0);
    chk("s2a_mo_out_b4", 32'(mo_out), 32'd1);
    chk("s2a_mo_cnt_b4", 32'(mo_cnt), 32'd2);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("s2a_mo_out_b6", 32'(mo_out), 32'd0);
    chk("s2a_me_out_b7", 32'(me_out), 32'd1);
    tick(0, 0, 0, 0);
    chk("s2a_mo_out_b7", 32'(mo_out), 32'd1);
    chk("s2a_mo_cnt", 32'(mo_cnt), 32'd3);
    chk("s2a_sa_cnt_sat", 32'(sa_cnt), 32'd3);

    // Scenario 2b: same stream, no overlap -> one hit
    cur_ov = 1'b0;
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    chk("s2b_mo_out_b4", 32'(mo_out), 32'd1);
    chk("s2b_mo_cnt_b4", 32'(mo_cnt), 32'd4);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("s2b_me_out_b7", 32'(me_out), 32'd0);
    tick(0, 0, 0, 0);
    chk("s2b_mo_out_b7", 32'(mo_out), 32'd0);
    chk("s2b_mo_cnt", 32'(mo_cnt), 32'd4);

    // Scenario 4: gapped valid, out holds across idle cycles
    cur_ov = 1'b1;
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 1); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 0, 1, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 0, 1, 1); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 0, 1, 1);
    chk("s4_me_out_b4", 32'(me_out), 32'd1);
    tick(0, 0, 0, 0);
    chk("s4_mo_out_idle1", 32'(mo_out), 32'd1);
    chk("s4_me_out_idle1", 32'(me_out), 32'd0);
    tick(0, 0, 0, 0);
    chk("s4_mo_out_idle2", 32'(mo_out), 32'd1);
    tick(0, 0, 1, 0);
    chk("s4_mo_out_nextbeat", 32'(mo_out), 32'd1);
    chk("s4_me_out_nextbeat", 32'(me_out), 32'd0);
    tick(0, 0, 0, 0);
    chk("s4_mo_out_drop", 32'(mo_out), 32'd0);
    chk("s4_mo_cnt", 32'(mo_cnt), 32'd5);

    // Scenario 5: 0000 with overlap, eight zeros -> 5 hits, 2-bit count pins at 3
    tick(1, 0, 0, 0);
    cur_pat = 4'b0000;
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0); tick(0, 0, 1, 0); tick(0, 0, 1, 0); tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    chk("s5_sa_cnt_b5", 32'(sa_cnt), 32'd1);
    tick(0, 0, 1, 0);
    chk("s5_sa_cnt_b6", 32'(sa_cnt), 32'd2);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    chk("s5_sa_cnt_b8", 32'(sa_cnt), 32'd3);
    tick(0, 0, 0, 0);
    chk("s5_sa_cnt_end", 32'(sa_cnt), 32'd3);
    chk("s5_sa_out", 32'(sa_out), 32'd1);
    chk("s5_mo_cnt", 32'(mo_cnt), 32'd5);

    // Scenario 6a: reset mid-stream; Mealy out forced low during reset
    tick(1, 0, 0, 0);
    cur_pat = 4'b1011;
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(1, 0, 1, 1);
    chk("s6a_me_out_in_reset", 32'(me_out), 32'd0);
    tick(0, 0, 1, 1);
    chk("s6a_me_out_post_reset", 32'(me_out), 32'd0);
    tick(0, 0, 0, 0);
    chk("s6a_mo_out", 32'(mo_out), 32'd0);
    chk("s6a_mo_cnt", 32'(mo_cnt), 32'd0);
    chk("s6a_me_cnt", 32'(me_cnt), 32'd0);

    // Scenario 6b: pat_load on the completing bit drops it and clears fill
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(0, 1, 1, 1);
    chk("s6b_me_out_load_beat", 32'(me_out), 32'd0);
    cur_pat = 4'b0000;
    tick(0, 0, 1, 1);
    chk("s6b_me_out_fill_cleared", 32'(me_out), 32'd0);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("s6b_me_out_full", 32'(me_out), 32'd1);
    tick(0, 0, 0, 0);
    chk("s6b_mo_out", 32'(mo_out), 32'd1);
    chk("s6b_mo_cnt", 32'(mo_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
